// File: rtl/ssram_seq.sv
// ssram_seq: single-clock sequencer between the KS-10 memory controller bus
// side and an external pipelined (ZBT) SSRAM. One request at a time: read,
// write, or read-modify-write (write-test), plus a no-op request that only
// produces a completion pulse.
//
// Optional feature: define MEM_NXM_EN to flag requests above MEM_TOP as
// nonexistent memory (no SSRAM cycle, nxm pulse after NXM_TIMEOUT cycles).
// Without MEM_NXM_EN every 20-bit word address goes to the SSRAM and nxm
// stays 0.

module ssram_seq #(
  parameter int          RD_LAT      = 2,           // 1..4
  parameter logic [19:0] MEM_TOP     = 20'd524287,
  parameter int          NXM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqVALID,
  output logic        reqREADY,
  input  logic        reqREAD,
  input  logic        reqWRITE,
  input  logic [19:0] reqADDR,
  input  logic [35:0] reqDATA,
  output logic        rspVALID,
  output logic [35:0] rspDATA,
  output logic        nxm,
  output logic        ssramCE,
  output logic        ssramWE_N,
  output logic        ssramOE_N,
  output logic        ssramADV,
  output logic [22:0] ssramADDR,
  output logic [35:0] ssramDOUT,
  output logic        ssramDOE,
  input  logic [35:0] ssramDIN
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDW,
    WR,
    WRW,
    NOP,
    DONE,
    NXW
  } state_t;

  // Latency counter reload: RDW/WRW last RD_LAT cycles, counting down to 0.
  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t      state;
  logic [2:0]  latCnt;
  logic        rmw;
  logic [19:0] addrQ;
  logic [35:0] wrData;

`ifdef MEM_NXM_EN
  localparam int NXW_W = $clog2(NXM_TIMEOUT + 1);
  logic [NXW_W-1:0] nxCnt;
`else
  // Address-range parameters only matter when the nonexistent-memory check
  // is built in; fold them into an unused net so the default build is clean.
  logic unusedCfg;
  assign unusedCfg = ^{MEM_TOP, 32'(NXM_TIMEOUT)};
`endif

  // Burst mode is never used; every access is a single-word cycle.
  assign ssramADV = 1'b0;

  // Request sequencer: state, captured request, and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      latCnt    <= '0;
      rmw       <= 1'b0;
      addrQ     <= '0;
      wrData    <= '0;
      reqREADY  <= 1'b0;
      rspVALID  <= 1'b0;
      rspDATA   <= '0;
      nxm       <= 1'b0;
      ssramCE   <= 1'b0;
      ssramWE_N <= 1'b1;
      ssramOE_N <= 1'b1;
      ssramADDR <= '0;
      ssramDOUT <= '0;
      ssramDOE  <= 1'b0;
`ifdef MEM_NXM_EN
      nxCnt     <= '0;
`endif
    end else begin
      // NOTE: every pulse-type output is given its idle value first, so each
      // state only lists what it asserts; non-blocking assignments make the
      // later per-state override win without any ordering hazard.
      rspVALID  <= 1'b0;
      nxm       <= 1'b0;
      ssramCE   <= 1'b0;
      ssramWE_N <= 1'b1;
      ssramOE_N <= 1'b1;
      ssramDOE  <= 1'b0;
      ssramDOUT <= '0;

      case (state)
        IDLE: begin
          reqREADY <= 1'b1;
          if (reqVALID && reqREADY) begin
            reqREADY <= 1'b0;
            addrQ    <= reqADDR;
            wrData   <= reqDATA;
            rmw      <= reqREAD && reqWRITE;
`ifdef MEM_NXM_EN
            if (reqADDR > MEM_TOP) begin
              state <= NXW;
              nxCnt <= NXW_W'(NXM_TIMEOUT - 1);
            end else
`endif
            if (reqREAD) begin
              // Read address phase (also first half of write-test).
              state     <= RD;
              ssramCE   <= 1'b1;
              ssramOE_N <= 1'b0;
              ssramADDR <= {3'b000, reqADDR};
            end else if (reqWRITE) begin
              state     <= WR;
              ssramCE   <= 1'b1;
              ssramWE_N <= 1'b0;
              ssramADDR <= {3'b000, reqADDR};
            end else begin
              state <= NOP;
            end
          end
        end

        RD: begin
          state     <= RDW;
          latCnt    <= LAT_LOAD;
          ssramOE_N <= 1'b0;
        end

        RDW: begin
          if (latCnt == 3'd0) begin
            rspDATA <= ssramDIN;
            if (rmw) begin
              // Write-test: old word captured, now issue the write phase.
              state     <= WR;
              ssramCE   <= 1'b1;
              ssramWE_N <= 1'b0;
              ssramADDR <= {3'b000, addrQ};
            end else begin
              state    <= DONE;
              rspVALID <= 1'b1;
            end
          end else begin
            latCnt    <= latCnt - 3'd1;
            ssramOE_N <= 1'b0;
          end
        end

        WR: begin
          state  <= WRW;
          latCnt <= LAT_LOAD;
          // With a one-cycle latency the data phase is the very next cycle.
          if (LAT_LOAD == 3'd0) begin
            ssramDOE  <= 1'b1;
            ssramDOUT <= wrData;
          end
        end

        WRW: begin
          if (latCnt == 3'd0) begin
            state    <= DONE;
            rspVALID <= 1'b1;
          end else begin
            latCnt <= latCnt - 3'd1;
            // Drive the pads in the cycle where the counter reaches 0.
            if (latCnt == 3'd1) begin
              ssramDOE  <= 1'b1;
              ssramDOUT <= wrData;
            end
          end
        end

        NOP: begin
          state    <= DONE;
          rspVALID <= 1'b1;
          rspDATA  <= '0;
        end

        DONE: begin
          state    <= IDLE;
          reqREADY <= 1'b1;
        end

`ifdef MEM_NXM_EN
        NXW: begin
          if (nxCnt == '0) begin
            state    <= IDLE;
            nxm      <= 1'b1;
            reqREADY <= 1'b1;
          end else begin
            nxCnt <= nxCnt - 1'b1;
          end
        end
`endif

        default: begin
          state    <= IDLE;
          reqREADY <= 1'b0;
        end
      endcase
    end
  end

endmodule
